// File: rtl/noc_pkg.sv
// Shared NoC definitions: check codes, packet type encodings, header field
// positions and the header flit builder.
package noc_pkg;

    localparam int unsigned FLIT_W = 128;
    localparam int unsigned CODE_W = 4;
    localparam int unsigned NODE_W = 4;
    localparam int unsigned TYPE_W = 3;
    localparam int unsigned LEN_W  = 8;
    localparam int unsigned PACK_W = 16;
    localparam int unsigned ADDR_W = 32;

    localparam logic [CODE_W-1:0] HEAD_CODE_H_DEF = 4'hA;
    localparam logic [CODE_W-1:0] HEAD_CODE_E_DEF = 4'hB;
    localparam logic [CODE_W-1:0] TAIL_CODE_H_DEF = 4'hC;
    localparam logic [CODE_W-1:0] TAIL_CODE_E_DEF = 4'hD;

    // MSB position of each header field
    localparam int unsigned CODE_H_MSB = 127;
    localparam int unsigned SRC_MSB    = 123;
    localparam int unsigned DEST_MSB   = 119;
    localparam int unsigned TYPE_MSB   = 115;
    localparam int unsigned LEN_MSB    = 112;
    localparam int unsigned PACK_MSB   = 104;
    localparam int unsigned ADDR_MSB   = 88;
    localparam int unsigned CODE_E_MSB = 56;

    typedef enum logic [TYPE_W-1:0] {
        PKT_WRITE = 3'b001,
        PKT_READ  = 3'b010
    } pkt_type_e;

    typedef enum logic [2:0] {
        IDLE,
        HEAD,
        BODY,
        TAIL,
        BRESP
    } state_e;

    function automatic logic [FLIT_W-1:0] build_header(
        input logic [CODE_W-1:0] code_h,
        input logic [CODE_W-1:0] code_e,
        input logic [NODE_W-1:0] src,
        input logic [NODE_W-1:0] dest,
        input pkt_type_e         typ,
        input logic [LEN_W-1:0]  len,
        input logic [PACK_W-1:0] pack_num,
        input logic [ADDR_W-1:0] addr
    );
        logic [FLIT_W-1:0] hdr;
        hdr = '0;
        hdr[CODE_H_MSB -: CODE_W] = code_h;
        hdr[SRC_MSB    -: NODE_W] = src;
        hdr[DEST_MSB   -: NODE_W] = dest;
        hdr[TYPE_MSB   -: TYPE_W] = typ;
        hdr[LEN_MSB    -: LEN_W]  = len;
        hdr[PACK_MSB   -: PACK_W] = pack_num;
        hdr[ADDR_MSB   -: ADDR_W] = addr;
        hdr[CODE_E_MSB -: CODE_W] = code_e;
        return hdr;
    endfunction

endpackage

// File: rtl/noc_flit_packer.sv
// Converts AXI write/read requests into NoC packets: a head flit, the write
// data beats (writes only) and a tail flit, followed by a B response for writes.
module noc_flit_packer
    import noc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 128,
    parameter int unsigned ID_WIDTH       = 4,
    parameter int unsigned VIRTUAL_CH_NUM = 16,
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter logic [ID_WIDTH-1:0] SRC_ID = 4'h0,
    parameter int unsigned HEAD_CODE_BIT  = 4,
    parameter int unsigned TAIL_CODE_BIT  = 4,
    parameter logic [HEAD_CODE_BIT-1:0] HEAD_CODE_H = HEAD_CODE_H_DEF,
    parameter logic [HEAD_CODE_BIT-1:0] HEAD_CODE_E = HEAD_CODE_E_DEF,
    parameter logic [TAIL_CODE_BIT-1:0] TAIL_CODE_H = TAIL_CODE_H_DEF,
    parameter logic [TAIL_CODE_BIT-1:0] TAIL_CODE_E = TAIL_CODE_E_DEF
) (
    input  logic                      axi_clk,
    input  logic                      axi_rst_n,
    input  logic                      awvalid,
    output logic                      awready,
    input  logic [AXI_ADDR_WIDTH-1:0] awaddr,
    input  logic [7:0]                awlen,
    input  logic                      wvalid,
    output logic                      wready,
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic                      wlast,
    output logic                      bvalid,
    input  logic                      bready,
    output logic [1:0]                bresp,
    input  logic                      arvalid,
    output logic                      arready,
    input  logic [AXI_ADDR_WIDTH-1:0] araddr,
    input  logic [7:0]                arlen,
    output logic [DATA_WIDTH:0]       axi2nocdata,
    output logic                      head,
    output logic                      tail,
    input  logic                      noc_buf_full
);

    state_e                    state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]                len_q, len_d;
    logic [7:0]                beat_q, beat_d;
    pkt_type_e                 type_q, type_d;
    logic [VIRTUAL_CH_NUM-1:0] pack_q, pack_d;
    logic                      rr_q, rr_d;   // 0: write wins a tie
    logic                      err_q, err_d;

    logic                  grant_w, grant_r, push, is_wr, in_tail;
    logic [DATA_WIDTH-1:0] flit, hdr_flit;

    assign is_wr   = (type_q == PKT_WRITE);
    assign in_tail = (state_q == TAIL);

    assign hdr_flit = DATA_WIDTH'(build_header(
        in_tail ? CODE_W'(TAIL_CODE_H) : CODE_W'(HEAD_CODE_H),
        in_tail ? CODE_W'(TAIL_CODE_E) : CODE_W'(HEAD_CODE_E),
        NODE_W'(SRC_ID),
        NODE_W'(addr_q[AXI_ADDR_WIDTH-1 -: ID_WIDTH]),
        type_q,
        len_q,
        PACK_W'(pack_q),
        ADDR_W'(addr_q)));

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        beat_d  = beat_q;
        type_d  = type_q;
        pack_d  = pack_q;
        rr_d    = rr_q;
        err_d   = err_q;
        grant_w = 1'b0;
        grant_r = 1'b0;
        push    = 1'b0;
        flit    = '0;
        case (state_q)
            IDLE: begin
                grant_w = awvalid && (!arvalid || !rr_q);
                grant_r = arvalid && !grant_w;
                if (grant_w) begin
                    addr_d = awaddr;
                    len_d  = awlen;
                    type_d = PKT_WRITE;
                end else if (grant_r) begin
                    addr_d = araddr;
                    len_d  = arlen;
                    type_d = PKT_READ;
                end
                if (grant_w || grant_r) begin
                    rr_d    = !rr_q;
                    beat_d  = '0;
                    state_d = HEAD;
                end
            end
            HEAD: begin
                push = !noc_buf_full;
                flit = hdr_flit;
                if (push) state_d = is_wr ? BODY : TAIL;
            end
            BODY: begin
                push = wvalid && !noc_buf_full;
                flit = wdata;
                if (push) begin
                    beat_d = beat_q + 8'd1;
                    // Beat count, not wlast, ends the body; a misplaced wlast only flags an error.
                    if (wlast != (beat_q == len_q)) err_d = 1'b1;
                    if (beat_q == len_q) state_d = TAIL;
                end
            end
            TAIL: begin
                push = !noc_buf_full;
                flit = hdr_flit;
                if (push) begin
                    pack_d  = pack_q + 1'b1;
                    state_d = is_wr ? BRESP : IDLE;
                end
            end
            BRESP: begin
                if (bready) begin
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge axi_clk or negedge axi_rst_n) begin
        if (!axi_rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            type_q  <= PKT_WRITE;
            pack_q  <= '0;
            rr_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            type_q  <= type_d;
            pack_q  <= pack_d;
            rr_q    <= rr_d;
            err_q   <= err_d;
        end
    end

    // Grants follow the request inputs directly, so they are masked while reset is held.
    assign awready     = axi_rst_n && grant_w;
    assign arready     = axi_rst_n && grant_r;
    assign wready      = (state_q == BODY) && !noc_buf_full;
    assign bvalid      = (state_q == BRESP);
    assign bresp       = (bvalid && err_q) ? 2'b10 : 2'b00;
    assign axi2nocdata = {push, flit};
    assign head        = push && (state_q == HEAD);
    assign tail        = push && in_tail;

endmodule

// File: tb/tb_noc_flit_packer.sv
// Directed self-checking bench for noc_flit_packer.
module tb_noc_flit_packer;

    localparam int DW = 128;

    logic          axi_clk = 1'b0;
    logic          axi_rst_n = 1'b0;
    logic          awvalid = 1'b0, arvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0;
    logic          bready = 1'b0, noc_buf_full = 1'b0;
    logic [31:0]   awaddr = '0, araddr = '0;
    logic [7:0]    awlen = '0, arlen = '0;
    logic [DW-1:0] wdata = '0;
    logic          awready, arready, wready, bvalid, head, tail;
    logic [1:0]    bresp;
    logic [DW:0]   axi2nocdata;

    int          total = 0;
    int          bad = 0;
    logic [15:0] pk = '0;
    logic [129:0] fq[$];

    noc_flit_packer #(
        .DATA_WIDTH(128),
        .ID_WIDTH(4),
        .VIRTUAL_CH_NUM(16),
        .AXI_ADDR_WIDTH(32),
        .SRC_ID(4'h0)
    ) dut (
        .axi_clk(axi_clk), .axi_rst_n(axi_rst_n),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
        .axi2nocdata(axi2nocdata), .head(head), .tail(tail),
        .noc_buf_full(noc_buf_full)
    );

    always #5 axi_clk = ~axi_clk;

    // Record every pushed flit as {head, tail, flit}
    always @(negedge axi_clk) begin
        if (axi2nocdata[DW] === 1'b1) fq.push_back({head, tail, axi2nocdata[DW-1:0]});
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [127:0] exp_hdr(input logic [3:0] ch, input logic [3:0] ce,
                                             input logic [3:0] dest, input logic [2:0] ty,
                                             input logic [7:0] len, input logic [15:0] pack,
                                             input logic [31:0] ad);
        return {ch, 4'h0, dest, ty, len, pack, ad, ce, 53'd0};
    endfunction

    function automatic logic [127:0] beat(input logic [31:0] base, input int i);
        logic [31:0] v;
        v = base + i[31:0];
        return {v, v, v, v};
    endfunction

    task automatic tick();
        @(posedge axi_clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input int last_idx,
                            input logic [31:0] base, output logic [1:0] resp);
        logic ok;
        awvalid = 1'b1; awaddr = addr; awlen = len;
        ok = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge axi_clk);
            ok = (awready === 1'b1);
            tick();
        end
        awvalid = 1'b0;
        if (!ok) begin total++; bad++; $display("FAIL aw_grant got=timeout exp=awready"); end
        for (int i = 0; i <= int'(len); i++) begin
            wvalid = 1'b1; wdata = beat(base, i); wlast = (i == last_idx);
            ok = 1'b0;
            for (int n = 0; n < 50 && !ok; n++) begin
                @(negedge axi_clk);
                ok = (wready === 1'b1);
                tick();
            end
            if (!ok) begin total++; bad++; $display("FAIL w_beat%0d got=timeout exp=wready", i); end
        end
        wvalid = 1'b0; wlast = 1'b0;
        ok = 1'b0; resp = 2'bxx;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge axi_clk);
            if (bvalid === 1'b1) begin ok = 1'b1; resp = bresp; bready = 1'b1; end
            tick();
        end
        bready = 1'b0;
        if (!ok) begin total++; bad++; $display("FAIL b_wait got=timeout exp=bvalid"); end
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, output logic saw_b);
        logic ok;
        arvalid = 1'b1; araddr = addr; arlen = len;
        ok = 1'b0; saw_b = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge axi_clk);
            ok = (arready === 1'b1);
            tick();
        end
        arvalid = 1'b0;
        if (!ok) begin total++; bad++; $display("FAIL ar_grant got=timeout exp=arready"); end
        repeat (3) begin
            @(negedge axi_clk);
            if (bvalid !== 1'b0) saw_b = 1'b1;
            tick();
        end
    endtask

    task automatic test_reset();
        logic [8:0] obs;
        axi_rst_n = 1'b0;
        awvalid = 1'b1; arvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        #2;
        obs = {awready, arready, wready, bvalid, axi2nocdata[DW], head, tail, bresp};
        total++;
        if (obs !== 9'd0) begin bad++; $display("FAIL reset_outputs got=%b exp=%b", obs, 9'd0); end
        awvalid = 1'b0; arvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
        tick();
        axi_rst_n = 1'b1;
        tick();
        pk = '0;
    endtask

    task automatic test_write();
        logic [1:0] resp;
        fq.delete();
        do_write(32'h3000_0040, 8'd1, 1, 32'h1111_0000, resp);
        total++;
        if (fq.size() != 4) begin bad++; $display("FAIL wr_count got=%0d exp=4", fq.size()); end
        total++;
        if (fq[0] !== {2'b10, exp_hdr(4'hA, 4'hB, 4'h3, 3'b001, 8'd1, pk, 32'h3000_0040)})
            begin bad++; $display("FAIL wr_head got=%h exp=head flit A/3/001/B", fq[0]); end
        total++;
        if (fq[1] !== {2'b00, beat(32'h1111_0000, 0)}) begin bad++; $display("FAIL wr_data0 got=%h", fq[1]); end
        total++;
        if (fq[2] !== {2'b00, beat(32'h1111_0000, 1)}) begin bad++; $display("FAIL wr_data1 got=%h", fq[2]); end
        total++;
        if (fq[3] !== {2'b01, exp_hdr(4'hC, 4'hD, 4'h3, 3'b001, 8'd1, pk, 32'h3000_0040)})
            begin bad++; $display("FAIL wr_tail got=%h exp=tail flit C/D", fq[3]); end
        total++;
        if (resp !== 2'b00) begin bad++; $display("FAIL wr_bresp got=%b exp=00", resp); end
        @(negedge axi_clk);
        total++;
        if (bvalid !== 1'b0) begin bad++; $display("FAIL wr_bvalid_drop got=%b exp=0", bvalid); end
        tick();
        pk++;
    endtask

    task automatic test_read();
        logic saw_b;
        fq.delete();
        do_read(32'h5000_0000, 8'd7, saw_b);
        total++;
        if (fq.size() != 2) begin bad++; $display("FAIL rd_count got=%0d exp=2", fq.size()); end
        total++;
        if (fq[0] !== {2'b10, exp_hdr(4'hA, 4'hB, 4'h5, 3'b010, 8'd7, pk, 32'h5000_0000)})
            begin bad++; $display("FAIL rd_head got=%h exp=head 010 len7", fq[0]); end
        total++;
        if (fq[1] !== {2'b01, exp_hdr(4'hC, 4'hD, 4'h5, 3'b010, 8'd7, pk, 32'h5000_0000)})
            begin bad++; $display("FAIL rd_tail got=%h exp=tail flit", fq[1]); end
        total++;
        if (saw_b !== 1'b0) begin bad++; $display("FAIL rd_no_bvalid got=%b exp=0", saw_b); end
        pk++;
    endtask

    task automatic test_rr();
        int    aw_rem, ar_rem, n;
        string ord;
        fq.delete();
        aw_rem = 2; ar_rem = 1; n = 0; ord = "";
        awaddr = 32'h1000_0000; awlen = 8'd0; araddr = 32'h2000_0000; arlen = 8'd0;
        wvalid = 1'b1; wlast = 1'b1; wdata = beat(32'h2222_0000, 0); bready = 1'b1;
        while ((aw_rem > 0 || ar_rem > 0) && n < 200) begin
            awvalid = (aw_rem > 0);
            arvalid = (ar_rem > 0);
            @(negedge axi_clk);
            if (awready === 1'b1) begin ord = {ord, "W"}; aw_rem--; end
            if (arready === 1'b1) begin ord = {ord, "R"}; ar_rem--; end
            tick();
            n++;
        end
        awvalid = 1'b0; arvalid = 1'b0;
        repeat (6) tick();
        wvalid = 1'b0; wlast = 1'b0; bready = 1'b0;
        total++;
        if (ord != "WRW") begin bad++; $display("FAIL rr_order got=%s exp=WRW", ord); end
        total++;
        if (fq.size() != 8) begin bad++; $display("FAIL rr_flits got=%0d exp=8", fq.size()); end
        pk += 16'd3;
    endtask

    task automatic test_backpressure();
        int   stall_ok;
        logic ok;
        fq.delete();
        awvalid = 1'b1; awaddr = 32'h7000_0000; awlen = 8'd3;
        @(negedge axi_clk);
        total++;
        if (awready !== 1'b1) begin bad++; $display("FAIL bp_awready got=%b exp=1", awready); end
        tick();
        @(negedge axi_clk);
        total++;
        if (awready !== 1'b0) begin bad++; $display("FAIL bp_awready_pulse got=%b exp=0", awready); end
        awvalid = 1'b0;
        tick();
        wvalid = 1'b1; wdata = beat(32'h3333_0000, 0); wlast = 1'b0;
        @(negedge axi_clk);
        total++;
        if (wready !== 1'b1) begin bad++; $display("FAIL bp_wready0 got=%b exp=1", wready); end
        tick();
        noc_buf_full = 1'b1; wdata = beat(32'h3333_0000, 1);
        stall_ok = 0;
        repeat (5) begin
            @(negedge axi_clk);
            if (wready === 1'b0 && axi2nocdata[DW] === 1'b0) stall_ok++;
            tick();
        end
        noc_buf_full = 1'b0;
        total++;
        if (stall_ok != 5) begin bad++; $display("FAIL bp_stall got=%0d exp=5", stall_ok); end
        ok = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            wdata = beat(32'h3333_0000, i); wlast = (i == 3);
            @(negedge axi_clk);
            if (wready !== 1'b1) ok = 1'b0;
            tick();
        end
        wvalid = 1'b0; wlast = 1'b0;
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL bp_resume got=%b exp=1", ok); end
        ok = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge axi_clk);
            if (bvalid === 1'b1) begin ok = 1'b1; bready = 1'b1; end
            tick();
        end
        bready = 1'b0;
        total++;
        if (fq.size() != 6) begin bad++; $display("FAIL bp_count got=%0d exp=6", fq.size()); end
        ok = (fq[0][129:128] === 2'b10) && (fq[5][129:128] === 2'b01);
        for (int i = 0; i < 4; i++)
            if (fq[i+1] !== {2'b00, beat(32'h3333_0000, i)}) ok = 1'b0;
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL bp_data got=corrupt exp=intact"); end
        pk++;
    endtask

    task automatic test_min_len();
        logic [1:0] resp;
        logic [5:0] marks;
        fq.delete();
        do_write(32'h4000_0000, 8'd0, 0, 32'h4444_0000, resp);
        marks = {fq[0][129:128], fq[1][129:128], fq[2][129:128]};
        total++;
        if (fq.size() != 3 || marks !== 6'b10_00_01)
            begin bad++; $display("FAIL len0 got=%0d/%b exp=3/100001", fq.size(), marks); end
        total++;
        if (resp !== 2'b00) begin bad++; $display("FAIL len0_bresp got=%b exp=00", resp); end
        pk++;
    endtask

    task automatic test_max_len();
        logic [1:0] resp;
        fq.delete();
        do_write(32'hB000_0000, 8'd255, 255, 32'h5555_0000, resp);
        total++;
        if (fq.size() != 258) begin bad++; $display("FAIL len255_count got=%0d exp=258", fq.size()); end
        total++;
        if (fq[0] !== {2'b10, exp_hdr(4'hA, 4'hB, 4'hB, 3'b001, 8'd255, pk, 32'hB000_0000)})
            begin bad++; $display("FAIL len255_head got=%h", fq[0]); end
        total++;
        if (fq[256] !== {2'b00, beat(32'h5555_0000, 255)} || fq[257][129:128] !== 2'b01)
            begin bad++; $display("FAIL len255_end got=%h / %b", fq[256], fq[257][129:128]); end
        total++;
        if (resp !== 2'b00) begin bad++; $display("FAIL len255_bresp got=%b exp=00", resp); end
        pk++;
    endtask

    task automatic test_wlast_err();
        logic [1:0] resp;
        logic       saw_b;
        axi_rst_n = 1'b0;
        tick();
        axi_rst_n = 1'b1;
        tick();
        fq.delete();
        do_write(32'h9000_0000, 8'd2, 1, 32'h6666_0000, resp);
        total++;
        if (fq.size() != 5) begin bad++; $display("FAIL wlast_count got=%0d exp=5", fq.size()); end
        total++;
        if (resp !== 2'b10) begin bad++; $display("FAIL wlast_bresp got=%b exp=10", resp); end
        total++;
        if (fq[0][104:89] !== 16'd0) begin bad++; $display("FAIL wlast_pack0 got=%0d exp=0", fq[0][104:89]); end
        fq.delete();
        do_read(32'h2000_0000, 8'd0, saw_b);
        total++;
        if (fq[0][104:89] !== 16'd1) begin bad++; $display("FAIL pack_inc got=%0d exp=1", fq[0][104:89]); end
        do_write(32'h9000_0000, 8'd0, 0, 32'h7777_0000, resp);
        total++;
        if (resp !== 2'b00) begin bad++; $display("FAIL err_cleared got=%b exp=00", resp); end
    endtask

    task automatic test_reset_mid();
        logic [8:0] obs;
        logic       saw_b;
        fq.delete();
        awvalid = 1'b1; awaddr = 32'hA000_0000; awlen = 8'd3;
        @(negedge axi_clk);
        tick();
        awvalid = 1'b0;
        tick();
        wvalid = 1'b1; wdata = beat(32'h8888_0000, 0); wlast = 1'b0;
        @(negedge axi_clk);
        tick();
        awvalid = 1'b1; arvalid = 1'b1; bready = 1'b1;
        axi_rst_n = 1'b0;
        @(negedge axi_clk);
        obs = {awready, arready, wready, bvalid, axi2nocdata[DW], head, tail, bresp};
        total++;
        if (obs !== 9'd0) begin bad++; $display("FAIL rstmid_outputs got=%b exp=%b", obs, 9'd0); end
        total++;
        if (fq.size() != 2 || fq[0][128] !== 1'b0 || fq[1][128] !== 1'b0)
            begin bad++; $display("FAIL rstmid_no_tail got=%0d flits exp=2 without tail", fq.size()); end
        awvalid = 1'b0; arvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
        tick();
        axi_rst_n = 1'b1;
        tick();
        fq.delete();
        do_read(32'h6000_0000, 8'd3, saw_b);
        total++;
        if (fq.size() != 2 || fq[0] !== {2'b10, exp_hdr(4'hA, 4'hB, 4'h6, 3'b010, 8'd3, 16'd0, 32'h6000_0000)})
            begin bad++; $display("FAIL rstmid_pack got=%h exp=pack 0 head", fq[0]); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_rr();
        test_backpressure();
        test_min_len();
        test_max_len();
        test_wlast_err();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/noc_flit_packer.md
NOC_FLIT_PACKER -- requirements
Module: noc_flit_packer

Interface
REQ-001 Parameters SHALL be, one per line:
 - DATA_WIDTH, 128, flit payload width
 - ID_WIDTH, 4, node ID width
 - VIRTUAL_CH_NUM, 16, PACK_NUM field width
 - AXI_ADDR_WIDTH, 32, AXI address width
 - SRC_ID, 4'h0, this node's ID
 - HEAD_CODE_BIT / TAIL_CODE_BIT, 4, check-code widths
 - HEAD_CODE_H / HEAD_CODE_E / TAIL_CODE_H / TAIL_CODE_E, 4'hA / 4'hB / 4'hC / 4'hD, check codes
REQ-002 Ports SHALL be (name, direction, width, meaning):
 - axi_clk, in, 1, clock
 - axi_rst_n, in, 1, reset: asynchronous, active-low
 - awvalid / awready, in / out, 1, write-address handshake
 - awaddr, in, AXI_ADDR_WIDTH, write address
 - awlen, in, 8, write beats minus one
 - wvalid / wready, in / out, 1, write-data handshake
 - wdata, in, DATA_WIDTH, write data
 - wlast, in, 1, last beat
 - bvalid / bready, out / in, 1, write-response handshake
 - bresp, out, 2, write response
 - arvalid / arready, in / out, 1, read-address handshake
 - araddr, in, AXI_ADDR_WIDTH, read address
 - arlen, in, 8, read beats minus one
 - axi2nocdata, out, DATA_WIDTH+1, {push, flit}
 - head / tail, out, 1, flit markers
 - noc_buf_full, in, 1, downstream FIFO full

Function
REQ-003 FSM states SHALL be IDLE, HEAD, BODY, TAIL, BRESP; reset state IDLE.
REQ-004 Arbitration in IDLE:
 - Only awvalid: grant write.
 - Only arvalid: grant read.
 - Both: round-robin; the pointer favours write after reset and toggles after each grant.
REQ-005 On grant, the matching awready/arready SHALL pulse for exactly one cycle; addr, len and type SHALL be latched; next state HEAD.
REQ-006 Header flit layout, MSB first:
 - code_h [127:124]
 - SRC_ID [123:120]
 - dest [119:116] = addr[AXI_ADDR_WIDTH-1 -: ID_WIDTH]
 - TYPE [115:113]: write 3'b001, read 3'b010
 - len [112:105]
 - PACK_NUM [104:89]
 - addr [88:57]
 - code_e [56:53]
 - 0 [52:0]
REQ-007 Push SHALL be combinational: axi2nocdata[DATA_WIDTH] = (state in HEAD/TAIL, or BODY with wvalid) AND NOT noc_buf_full; state advances only on push.
REQ-008 HEAD SHALL emit the header with HEAD codes and head=1, tail=0; next state BODY for write, TAIL for read.
REQ-009 BODY flits:
 - wready = (state==BODY) AND NOT noc_buf_full.
 - Each accepted beat pushes wdata unmodified, with head=tail=0.
 - After awlen+1 beats, next state TAIL.
REQ-010 TAIL SHALL emit the header with TAIL codes and head=0, tail=1; next state BRESP for write, IDLE for read.
REQ-011 PACK_NUM SHALL be a 16-bit counter, incremented on each tail push and wrapping 16'hFFFF to 0.
REQ-012 wlast check: wlast SHALL be high on beat awlen+1 only. Any mismatch SHALL set a sticky error for the packet, giving bresp=2'b10 (SLVERR); otherwise bresp=2'b00. Flit count is always awlen+1.
REQ-013 BRESP state:
 - bvalid held high until bready; bresp stable while bvalid is high.
 - On the handshake: clear the error flag, next state IDLE.
REQ-014 Backpressure: noc_buf_full held for N cycles SHALL stall the FSM for exactly N cycles, with no flit lost or duplicated.
REQ-015 When not pushing, head, tail and the push bit SHALL be 0; flit bits are don't-care.
REQ-016 awlen=0 SHALL produce exactly 3 flits (head, body, tail); awlen=255 SHALL produce 258.

Reset
REQ-017 Asserting axi_rst_n low at any time SHALL immediately force:
 - state IDLE, PACK_NUM 0, RR pointer to write, error flag 0
 - all ready outputs, bvalid, push bit, head and tail to 0
 - bresp 2'b00
REQ-018 A packet in progress at reset SHALL be discarded with no tail emitted; the downstream FIFO reset is handled separately.

Structure
REQ-019 Shared package noc_pkg SHALL hold the check codes, TYPE encodings and header field offsets, plus a header-build function taking codes, dest, type, len, pack_num and addr.
REQ-020 No sub-module; the round-robin arbiter SHALL be inline (two requesters).

Verification
REQ-021 Write, awaddr=32'h3000_0040, awlen=1, 2 beats, noc_buf_full=0 -> 4 pushes:
 - head flit: [127:124]=A, [119:116]=3, TYPE=001, [56:53]=B
 - 2 data flits
 - tail flit: [127:124]=C, [56:53]=D
 - then bvalid with bresp=00
REQ-022 Read, araddr=32'h5000_0000, arlen=7 -> 2 pushes: head with TYPE=010 and len=7, then tail; no bvalid.
REQ-023 awvalid and arvalid high in the same cycle, twice -> order is write, read, write.
REQ-024 noc_buf_full=1 for 5 cycles during BODY -> wready low and no push for 5 cycles; all data then arrives intact.
REQ-025 awlen=2 with wlast on beat 2 -> 5 flits, bresp=2'b10; PACK_NUM increments 0 to 1.
REQ-026 axi_rst_n low mid-BODY -> all outputs 0 next sample, state IDLE; the next packet carries PACK_NUM=0.
